// File: rtl/fsm3lanpc_nph_pkg.sv
// Shared types, gate patterns and delay-class selection for the ANPC leg sequencer.
package PKG_fsm3lanpc;

  typedef enum logic [1:0] {
    LEV_ZERO = 2'b00,
    LEV_P    = 2'b01,
    LEV_N    = 2'b10,
    LEV_OFF  = 2'b11
  } level_e;

  typedef enum logic [1:0] {
    ZT_DFLT = 2'd0,
    ZT_ZU   = 2'd1,
    ZT_ZL   = 2'd2,
    ZT_ZF   = 2'd3
  } ztype_e;

  typedef enum logic [1:0] {
    LEG_OFF    = 2'd0,
    LEG_STEADY = 2'd1,
    LEG_WAIT   = 2'd2
  } leg_state_e;

  typedef enum logic [2:0] {
    DLY_NONE     = 3'd0,
    DLY_SHORT    = 3'd1,
    DLY_OFF_ON   = 3'd2,
    DLY_ON_OFFV0 = 3'd3,
    DLY_OFFV0_ON = 3'd4,
    DLY_OFF_ONI0 = 3'd5
  } dly_sel_e;

  // Gate patterns, bit0..5 = S1..S6
  localparam logic [5:0] PAT_P   = 6'b100011;
  localparam logic [5:0] PAT_N   = 6'b011100;
  localparam logic [5:0] PAT_ZU  = 6'b010010;
  localparam logic [5:0] PAT_ZL  = 6'b100100;
  localparam logic [5:0] PAT_ZF  = 6'b110110;
  localparam logic [5:0] PAT_OFF = 6'b000000;

  function automatic logic [5:0] lev_pat(input level_e lev, input logic [1:0] zt);
    logic [5:0] pat;
    pat = PAT_OFF;
    case (lev)
      LEV_P:   pat = PAT_P;
      LEV_N:   pat = PAT_N;
      LEV_ZERO: begin
        case (ztype_e'(zt))
          ZT_ZL:   pat = PAT_ZL;
          ZT_ZF:   pat = PAT_ZF;
          default: pat = PAT_ZU;
        endcase
      end
      default: pat = PAT_OFF;
    endcase
    return pat;
  endfunction

  // Dead-time class for a transition between two levels
  function automatic dly_sel_e dly_sel(input level_e cur, input level_e tgt);
    dly_sel_e sel;
    if (tgt == LEV_OFF)
      sel = DLY_NONE;
    else if (cur == LEV_OFF)
      sel = (tgt == LEV_ZERO) ? DLY_OFF_ONI0 : DLY_OFF_ON;
    else if (cur == LEV_ZERO)
      sel = (tgt == LEV_ZERO) ? DLY_SHORT : DLY_OFFV0_ON;
    else
      sel = DLY_ON_OFFV0;
    return sel;
  endfunction

endpackage

// File: rtl/fsm3lanpc_leg.sv
// One ANPC leg: level-to-gate conversion with break-before-make dead-time waits.
module fsm3lanpc_leg
  import PKG_fsm3lanpc::*;
#(
  parameter int unsigned TD_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_kill,
  input  logic [TD_W-1:0] i_t_short,
  input  logic [TD_W-1:0] i_t_off_on,
  input  logic [TD_W-1:0] i_t_on_offv0,
  input  logic [TD_W-1:0] i_t_offv0_on,
  input  logic [TD_W-1:0] i_t_off_oni0,
  input  logic [1:0]      i_v_lev,
  input  logic [1:0]      i_z_type,
  output logic [5:0]      o_s,
  output logic            o_busy
);

  leg_state_e      r_state;
  level_e          r_cur_lev;
  level_e          r_tgt_lev;
  logic [5:0]      r_cur_pat;
  logic [5:0]      r_tgt_pat;
  logic [TD_W-1:0] r_cnt;
  logic [5:0]      r_gate;
  logic            r_busy;

  level_e          w_cmd_lev;
  level_e          w_tgt_lev;
  logic [5:0]      w_tgt_pat;
  dly_sel_e        w_sel;
  logic [TD_W-1:0] w_dly;
  logic [TD_W-1:0] w_load;

  // Next target: P<->N is split into a detour through the zero pattern
  always_comb begin
    w_cmd_lev = level_e'(i_v_lev);
    w_tgt_lev = w_cmd_lev;
    if ((r_cur_lev == LEV_P && w_cmd_lev == LEV_N) ||
        (r_cur_lev == LEV_N && w_cmd_lev == LEV_P))
      w_tgt_lev = LEV_ZERO;
    w_tgt_pat = lev_pat(w_tgt_lev, i_z_type);
    w_sel     = dly_sel(r_cur_lev, w_tgt_lev);
    case (w_sel)
      DLY_SHORT:    w_dly = i_t_short;
      DLY_OFF_ON:   w_dly = i_t_off_on;
      DLY_ON_OFFV0: w_dly = i_t_on_offv0;
      DLY_OFFV0_ON: w_dly = i_t_offv0_on;
      DLY_OFF_ONI0: w_dly = i_t_off_oni0;
      default:      w_dly = '0;
    endcase
    w_load = (w_dly == '0) ? '0 : w_dly - TD_W'(1);
  end

  // Leg FSM; the counter doubles as the delay shadow captured at wait entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= LEG_OFF;
      r_cur_lev <= LEV_OFF;
      r_tgt_lev <= LEV_OFF;
      r_cur_pat <= PAT_OFF;
      r_tgt_pat <= PAT_OFF;
      r_cnt     <= '0;
      r_gate    <= PAT_OFF;
      r_busy    <= 1'b0;
    end else if (i_kill) begin
      r_state   <= LEG_OFF;
      r_cur_lev <= LEV_OFF;
      r_tgt_lev <= LEV_OFF;
      r_cur_pat <= PAT_OFF;
      r_tgt_pat <= PAT_OFF;
      r_cnt     <= '0;
      r_gate    <= PAT_OFF;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        LEG_OFF, LEG_STEADY: begin
          if (w_tgt_pat != r_cur_pat) begin
            if (w_tgt_lev == LEV_OFF) begin
              r_state   <= LEG_OFF;
              r_cur_lev <= LEV_OFF;
              r_cur_pat <= PAT_OFF;
              r_gate    <= PAT_OFF;
              r_busy    <= 1'b0;
            end else begin
              r_state   <= LEG_WAIT;
              r_tgt_lev <= w_tgt_lev;
              r_tgt_pat <= w_tgt_pat;
              r_cnt     <= w_load;
              r_gate    <= r_cur_pat & w_tgt_pat;
              r_busy    <= 1'b1;
            end
          end
        end
        LEG_WAIT: begin
          if (r_cnt == '0) begin
            r_state   <= LEG_STEADY;
            r_cur_lev <= r_tgt_lev;
            r_cur_pat <= r_tgt_pat;
            r_gate    <= r_tgt_pat;
            r_busy    <= 1'b0;
          end else begin
            r_cnt <= r_cnt - TD_W'(1);
          end
        end
        default: begin
          r_state <= LEG_OFF;
          r_gate  <= PAT_OFF;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_s    = r_gate;
  assign o_busy = r_busy;

endmodule

// File: rtl/fsm3lanpc_nph.sv
// N-phase ANPC gate sequencer: shared timing, global enable and fault shutdown.
// Build option: FSM3LANPC_FAULT_LATCH_EN latches fault until fault_clr.
module fsm3lanpc_nph
  import PKG_fsm3lanpc::*;
#(
  parameter int unsigned NPH  = 3,
  parameter int unsigned TD_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              fault,
  input  logic              fault_clr,
  input  logic [TD_W-1:0]   t_short,
  input  logic [TD_W-1:0]   t_off_on,
  input  logic [TD_W-1:0]   t_on_offV0,
  input  logic [TD_W-1:0]   t_offV0_on,
  input  logic [TD_W-1:0]   t_off_onI0,
  input  logic [2*NPH-1:0]  v_lev,
  input  logic [2*NPH-1:0]  z_type,
  output logic [6*NPH-1:0]  S_out,
  output logic [NPH-1:0]    busy,
  output logic              fault_q
);

  logic r_fault;
  logic w_fault_act;
  logic w_kill;

`ifdef FSM3LANPC_FAULT_LATCH_EN
  // Sticky fault; a clear is only honoured once the request has gone away
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_fault <= 1'b0;
    else if (fault)
      r_fault <= 1'b1;
    else if (fault_clr)
      r_fault <= 1'b0;
  end
  assign w_fault_act = fault | r_fault;
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_fault <= 1'b0;
    else
      r_fault <= fault;
  end
  assign w_fault_act = fault;
  logic w_unused_fault_clr;
  assign w_unused_fault_clr = fault_clr;
`endif

  assign fault_q = r_fault;
  assign w_kill  = ~enable | w_fault_act;

  for (genvar g = 0; g < NPH; g++) begin : g_leg
    fsm3lanpc_leg #(.TD_W(TD_W)) u_leg (
      .clk          (clk),
      .reset        (reset),
      .i_kill       (w_kill),
      .i_t_short    (t_short),
      .i_t_off_on   (t_off_on),
      .i_t_on_offv0 (t_on_offV0),
      .i_t_offv0_on (t_offV0_on),
      .i_t_off_oni0 (t_off_onI0),
      .i_v_lev      (v_lev[2*g +: 2]),
      .i_z_type     (z_type[2*g +: 2]),
      .o_s          (S_out[6*g +: 6]),
      .o_busy       (busy[g])
    );
  end

endmodule

// File: tb/tb_fsm3lanpc_nph.sv
// Directed bench for fsm3lanpc_nph (NPH=3): dead-time sequencing, shadowing, fault and enable.
module tb_fsm3lanpc_nph;

  localparam int unsigned NPH  = 3;
  localparam int unsigned TD_W = 16;

  logic              clk;
  logic              reset;
  logic              enable;
  logic              fault;
  logic              fault_clr;
  logic [TD_W-1:0]   t_short;
  logic [TD_W-1:0]   t_off_on;
  logic [TD_W-1:0]   t_on_offV0;
  logic [TD_W-1:0]   t_offV0_on;
  logic [TD_W-1:0]   t_off_onI0;
  logic [2*NPH-1:0]  v_lev;
  logic [2*NPH-1:0]  z_type;
  logic [6*NPH-1:0]  S_out;
  logic [NPH-1:0]    busy;
  logic              fault_q;

  int checks = 0;
  int errors = 0;

  fsm3lanpc_nph #(.NPH(NPH), .TD_W(TD_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .fault      (fault),
    .fault_clr  (fault_clr),
    .t_short    (t_short),
    .t_off_on   (t_off_on),
    .t_on_offV0 (t_on_offV0),
    .t_offV0_on (t_offV0_on),
    .t_off_onI0 (t_off_onI0),
    .v_lev      (v_lev),
    .z_type     (z_type),
    .S_out      (S_out),
    .busy       (busy),
    .fault_q    (fault_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; fault = 1'b0; fault_clr = 1'b0;
    t_short = 16'd10; t_off_on = 16'd10; t_on_offV0 = 16'd10;
    t_offV0_on = 16'd10; t_off_onI0 = 16'd10;
    v_lev = 6'b111111; z_type = 6'b010101;
    tick(); tick();
    checks++;
    if (S_out !== 18'd0 || busy !== 3'b000 || fault_q !== 1'b0) begin
      errors++;
      $display("FAIL reset S_out=%b busy=%b fault_q=%b exp 0/0/0", S_out, busy, fault_q);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (S_out !== 18'd0 || busy !== 3'b000) begin
      errors++;
      $display("FAIL idle_off S_out=%b busy=%b exp 0/0", S_out, busy);
    end
  endtask

  task automatic test_off_to_p();
    v_lev[1:0] = 2'b01;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (S_out[5:0] !== 6'b000000 || busy !== 3'b001) begin
        errors++;
        $display("FAIL off_p_wait cyc%0d S=%b busy=%b exp 000000/001", i, S_out[5:0], busy);
      end
    end
    tick();
    checks++;
    if (S_out !== {12'd0, 6'b100011} || busy !== 3'b000) begin
      errors++;
      $display("FAIL off_p_done S_out=%b busy=%b exp P on phase0", S_out, busy);
    end
  endtask

  task automatic test_p_to_zu();
    t_on_offV0 = 16'd7;
    v_lev[1:0] = 2'b00;
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if (S_out[5:0] !== 6'b000010 || busy[0] !== 1'b1) begin
        errors++;
        $display("FAIL p_zu_wait cyc%0d S=%b busy=%b exp 000010/1", i, S_out[5:0], busy[0]);
      end
    end
    tick();
    checks++;
    if (S_out[5:0] !== 6'b010010 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL p_zu_done S=%b busy=%b exp 010010/0", S_out[5:0], busy[0]);
    end
  endtask

  task automatic test_p_to_n();
    t_offV0_on = 16'd6;
    v_lev[1:0] = 2'b01;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (S_out[5:0] !== 6'b000010 || busy[0] !== 1'b1) begin
        errors++;
        $display("FAIL zu_p_wait cyc%0d S=%b exp 000010 busy1", i, S_out[5:0]);
      end
    end
    tick();
    checks++;
    if (S_out[5:0] !== 6'b100011) begin
      errors++;
      $display("FAIL zu_p_done S=%b exp 100011", S_out[5:0]);
    end
    z_type[1:0] = 2'd3;
    tick();
    checks++;
    if (S_out[5:0] !== 6'b100011 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL ztype_while_p S=%b busy=%b exp 100011/0", S_out[5:0], busy[0]);
    end
    v_lev[1:0] = 2'b10;
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if (S_out[5:0] !== 6'b100010 || busy[0] !== 1'b1) begin
        errors++;
        $display("FAIL pn_first cyc%0d S=%b busy=%b exp 100010/1", i, S_out[5:0], busy[0]);
      end
    end
    tick();
    checks++;
    if (S_out[5:0] !== 6'b110110 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL pn_mid S=%b busy=%b exp 110110/0", S_out[5:0], busy[0]);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (S_out[5:0] !== 6'b010100 || busy[0] !== 1'b1) begin
        errors++;
        $display("FAIL pn_second cyc%0d S=%b busy=%b exp 010100/1", i, S_out[5:0], busy[0]);
      end
    end
    tick();
    checks++;
    if (S_out[5:0] !== 6'b011100 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL pn_done S=%b busy=%b exp 011100/0", S_out[5:0], busy[0]);
    end
  endtask

  task automatic test_shadow();
    t_short = 16'd3;
    z_type[1:0] = 2'd1;
    v_lev[1:0] = 2'b00;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (S_out[5:0] !== 6'b010010 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL n_zu_done S=%b exp 010010", S_out[5:0]);
    end
    z_type[1:0] = 2'd2;
    tick();
    checks++;
    if (S_out[5:0] !== 6'b000000 || busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL zu_zl_enter S=%b busy=%b exp 000000/1", S_out[5:0], busy[0]);
    end
    t_short = 16'd20;
    tick(); tick();
    checks++;
    if (busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL zu_zl_hold busy=%b exp 1", busy[0]);
    end
    tick();
    checks++;
    if (S_out[5:0] !== 6'b100100 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL shadow_len S=%b busy=%b exp 100100/0", S_out[5:0], busy[0]);
    end
    z_type[1:0] = 2'd3;
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (S_out[5:0] !== 6'b100100 || busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL new_short_hold S=%b busy=%b exp 100100/1", S_out[5:0], busy[0]);
    end
    tick();
    checks++;
    if (S_out[5:0] !== 6'b110110 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL new_short_done S=%b busy=%b exp 110110/0", S_out[5:0], busy[0]);
    end
  endtask

  task automatic test_fault();
    t_off_onI0 = 16'd4;
    v_lev = 6'b000101;
    tick();
    checks++;
    if (busy !== 3'b111 || S_out !== {6'b000000, 6'b000000, 6'b100010}) begin
      errors++;
      $display("FAIL all_wait S_out=%b busy=%b exp busy 111", S_out, busy);
    end
    fault = 1'b1;
    tick();
    checks++;
    if (S_out !== 18'd0 || busy !== 3'b000 || fault_q !== 1'b1) begin
      errors++;
      $display("FAIL fault_off S_out=%b busy=%b fault_q=%b exp 0/0/1", S_out, busy, fault_q);
    end
    fault = 1'b0;
    tick();
`ifdef FSM3LANPC_FAULT_LATCH_EN
    checks++;
    if (S_out !== 18'd0 || busy !== 3'b000 || fault_q !== 1'b1) begin
      errors++;
      $display("FAIL fault_latched S_out=%b busy=%b fault_q=%b exp 0/0/1", S_out, busy, fault_q);
    end
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    checks++;
    if (fault_q !== 1'b0 || busy !== 3'b000) begin
      errors++;
      $display("FAIL fault_clr fault_q=%b busy=%b exp 0/000", fault_q, busy);
    end
    tick();
`endif
    checks++;
    if (S_out !== 18'd0 || busy !== 3'b111 || fault_q !== 1'b0) begin
      errors++;
      $display("FAIL restart S_out=%b busy=%b fault_q=%b exp 0/111/0", S_out, busy, fault_q);
    end
    tick(); tick(); tick();
    checks++;
    if (S_out !== 18'd0 || busy !== 3'b111) begin
      errors++;
      $display("FAIL restart_hold S_out=%b busy=%b exp 0/111", S_out, busy);
    end
    tick();
    checks++;
    if (S_out !== {6'b010010, 12'd0} || busy !== 3'b011) begin
      errors++;
      $display("FAIL restart_zero S_out=%b busy=%b exp ZU on phase2/011", S_out, busy);
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (busy !== 3'b011) begin
      errors++;
      $display("FAIL restart_p_hold busy=%b exp 011", busy);
    end
    tick();
    checks++;
    if (S_out !== {6'b010010, 6'b100011, 6'b100011} || busy !== 3'b000) begin
      errors++;
      $display("FAIL restart_p S_out=%b busy=%b exp ZU,P,P/000", S_out, busy);
    end
  endtask

  task automatic test_enable_zero_delay();
    enable = 1'b0;
    tick();
    checks++;
    if (S_out !== 18'd0 || busy !== 3'b000 || fault_q !== 1'b0) begin
      errors++;
      $display("FAIL disable S_out=%b busy=%b fault_q=%b exp 0/0/0", S_out, busy, fault_q);
    end
    t_short = '0; t_off_on = '0; t_on_offV0 = '0; t_offV0_on = '0; t_off_onI0 = '0;
    z_type[1:0] = 2'd1;
    enable = 1'b1;
    tick();
    checks++;
    if (S_out !== 18'd0 || busy !== 3'b111) begin
      errors++;
      $display("FAIL zd_restart S_out=%b busy=%b exp 0/111", S_out, busy);
    end
    tick();
    checks++;
    if (S_out !== {6'b010010, 6'b100011, 6'b100011} || busy !== 3'b000) begin
      errors++;
      $display("FAIL zd_restart_done S_out=%b busy=%b exp ZU,P,P/000", S_out, busy);
    end
    v_lev[1:0] = 2'b10;
    v_lev[3:2] = 2'b11;
    tick();
    checks++;
    if (S_out[5:0] !== 6'b000010 || busy !== 3'b001 || S_out[11:6] !== 6'b000000) begin
      errors++;
      $display("FAIL zd_pn1 S_out=%b busy=%b exp ph0 000010 ph1 0 busy 001", S_out, busy);
    end
    tick();
    checks++;
    if (S_out[5:0] !== 6'b010010 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL zd_pn2 S=%b busy=%b exp 010010/0", S_out[5:0], busy[0]);
    end
    tick();
    checks++;
    if (S_out[5:0] !== 6'b010000 || busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL zd_pn3 S=%b busy=%b exp 010000/1", S_out[5:0], busy[0]);
    end
    tick();
    checks++;
    if (S_out[5:0] !== 6'b011100 || busy !== 3'b000) begin
      errors++;
      $display("FAIL zd_pn4 S=%b busy=%b exp 011100/000", S_out[5:0], busy);
    end
  endtask

  task automatic test_async_reset();
    v_lev[1:0] = 2'b01;
    t_on_offV0 = 16'd9;
    tick();
    #2 reset = 1'b0;
    #1;
    checks++;
    if (S_out !== 18'd0 || busy !== 3'b000) begin
      errors++;
      $display("FAIL async_reset S_out=%b busy=%b exp 0/0", S_out, busy);
    end
    tick();
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_off_to_p();
    test_p_to_zu();
    test_p_to_n();
    test_shadow();
    test_fault();
    test_enable_zero_delay();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
